// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// FSM encoding, frame timing constants and the parity select helper.
package uart_tx_arbiter_pkg;

  // Arbiter FSM encoding. FLUSH is the post-reset state.
  typedef enum logic [2:0] {
    ST_FLUSH     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_NEXT      = 3'd4
  } state_t;

  // One UART frame: 11 bits at 27 clocks per bit.
  localparam int FRAME_BITS         = 11;
  localparam int BIT_CYCLES         = 27;
  localparam int FRAME_CYCLES       = FRAME_BITS * BIT_CYCLES;

  // Default WAIT_DONE budget: one frame plus margin.
  localparam int TIMEOUT_CYCLES_DEF = 400;

  // Parity type presented to the transmitter for a given owner.
  function automatic logic parity_sel(input logic gid,
                                      input logic p0,
                                      input logic p1);
    logic sel;
    if (gid) begin
      sel = p1;
    end else begin
      sel = p0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Two-way round-robin picker. With a single requester it grants that one;
// with both it grants the one that did not win last time.
module uart_tx_arbiter_rr (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_grant_id,
  output logic       o_grant_valid
);

  // Pick a winner from the two valid lines and the previous owner.
  always_comb begin
    o_grant_id    = i_last_grant;
    o_grant_valid = 1'b0;
    case (i_valid)
      2'b01: begin
        o_grant_id    = 1'b0;
        o_grant_valid = 1'b1;
      end
      2'b10: begin
        o_grant_id    = 1'b1;
        o_grant_valid = 1'b1;
      end
      2'b11: begin
        o_grant_id    = ~i_last_grant;
        o_grant_valid = 1'b1;
      end
      default: begin
        o_grant_id    = i_last_grant;
        o_grant_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte/packet sources onto one UART transmitter. A packet
// owner keeps the transmitter until a last byte completes or a frame times
// out. After reset the FSM waits in FLUSH for any frame already in flight.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic PARITY0        = 1'b0,
  parameter logic PARITY1        = 1'b1
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       parity_type,
  input  logic       tx_done,
  output logic       busy,
  output logic       grant_id,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lock;
  logic             r_grant_id;
  logic [7:0]       r_tx_data;
  logic             r_parity;
  logic             r_tx_start;
  logic             r_busy;
  logic             r_timeout_err;

  logic             w_rr_gid;
  logic             w_rr_valid;
  logic             w_own_valid;
  logic             w_cnt_last;
  logic             w_accept;
  logic             w_acc_id;
  logic [7:0]       w_acc_data;
  logic             w_acc_last;
  logic             w_timeout;

  uart_tx_arbiter_rr u_rr (
    .i_valid       ({req1_valid, req0_valid}),
    .i_last_grant  (r_grant_id),
    .o_grant_id    (w_rr_gid),
    .o_grant_valid (w_rr_valid)
  );

  assign w_own_valid = r_grant_id ? req1_valid : req0_valid;
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_acc_data  = w_acc_id ? req1_data : req0_data;
  assign w_acc_last  = w_acc_id ? req1_last : req0_last;

  // Handshake is combinational with the accept decision; held low in reset
  // so no byte appears taken while the packet is being dropped.
  assign req0_ready  = rst_n & w_accept & ~w_acc_id;
  assign req1_ready  = rst_n & w_accept &  w_acc_id;

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign parity_type = r_parity;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;

  // Next-state, accept and timeout decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_acc_id    = r_grant_id;
    w_timeout   = 1'b0;
    case (r_state)
      ST_FLUSH: begin
        if (tx_done || w_cnt_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_IDLE: begin
        if (w_rr_valid) begin
          w_accept    = 1'b1;
          w_acc_id    = w_rr_gid;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (r_lock) begin
            w_state_nxt = ST_NEXT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_cnt_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_NEXT: begin
        if (w_own_valid) begin
          w_accept    = 1'b1;
          w_acc_id    = r_grant_id;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_NEXT;
        end
      end
      default: begin
        w_state_nxt = ST_FLUSH;
      end
    endcase
  end

  // State register; reset lands in FLUSH.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      r_state <= ST_FLUSH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dwell counter: restarts on every state change, saturates at the limit.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != w_state_nxt) begin
      r_cnt <= '0;
    end else if (!w_cnt_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Byte, owner, parity and packet lock captured on each accepted byte.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      r_tx_data  <= 8'h00;
      r_parity   <= PARITY0;
      r_grant_id <= 1'b1;
      r_lock     <= 1'b0;
    end else if (w_accept) begin
      r_tx_data  <= w_acc_data;
      r_parity   <= parity_sel(w_acc_id, PARITY0, PARITY1);
      r_grant_id <= w_acc_id;
      r_lock     <= ~w_acc_last;
    end else if (w_timeout) begin
      r_lock     <= 1'b0;
    end else begin
      r_lock     <= r_lock;
    end
  end

  // Registered status: start pulse and busy follow the next state.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      r_tx_start <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_tx_start <= (w_state_nxt == ST_START);
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= r_timeout_err;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter. A transaction/timeline model
// predicts handshakes, start pulses, held byte/parity, busy, owner and the
// sticky error from cycle stamps of accepts, completions and timeouts.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int   TO = 400;
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  logic       clk_3125 = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, tx_start, parity_type, busy, grant_id, timeout_err;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0, err_clr = 1'b0;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO), .PARITY0(P0), .PARITY1(P1)) dut (
    .clk_3125(clk_3125), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .parity_type(parity_type), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #160 clk_3125 = ~clk_3125;

  int n_checks = 0, n_fail = 0, cyc = 0;

  // Stimulus controls
  logic [8:0] q0[$], q1[$];
  int rst_cnt = 0, v_pct = 100, tx_mode = 0, tx_fixed = 297;
  int stray_pct = 0, clr_pct = 0, stray_flush_dly = 0, stray_at = -1;
  bit clr_at_to = 0, clr_once = 0;

  // Reference model state
  bit m_armed = 0, m_flush = 0, m_infl = 0, m_locked = 0, m_last = 1, m_err = 0;
  bit m_lastflag = 0, m_chk_rst = 0, m_par = 0;
  int m_flush_start = 0, m_avail = 0, m_start = 0, m_done_at = -1;
  logic [7:0] m_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick_dly();
    int r;
    if (tx_mode == 0) return tx_fixed;
    r = $urandom_range(99);
    if (r < 3) return 0;
    if (r < 6) return $urandom_range(405, 395);
    return $urandom_range(40, 1);
  endfunction

  function automatic bit model_idle();
    return m_armed && !m_flush && !m_infl && !m_locked && (cyc + 1 >= m_avail);
  endfunction

  task automatic step();
    bit idle_s, in_wait, acc, who, to, done_s, clr_s;
    int entry, dly;
    logic [8:0] h0, h1, h;
    @(posedge clk_3125); #1; cyc++;
    entry = m_start + 1;
    if (m_armed) begin
      idle_s = !m_flush && !m_infl && !m_locked && (cyc >= m_avail);
      chk("tx_start", tx_start, (m_infl && cyc == m_start));
      chk("busy", busy, !idle_s);
      chk("grant_id", grant_id, m_last);
      chk("timeout_err", timeout_err, m_err);
      if (m_infl && cyc >= m_start) begin
        chk("tx_data", tx_data, m_data);
        chk("parity_type", parity_type, m_par);
      end
      if (m_chk_rst) begin
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_parity", parity_type, P0);
        m_chk_rst = 0;
      end
    end
    // drive inputs for this cycle
    rst_n = (rst_cnt > 0) ? 1'b0 : 1'b1;
    if (rst_cnt > 0) rst_cnt--;
    h0 = (q0.size() > 0) ? q0[0] : 9'h000;
    h1 = (q1.size() > 0) ? q1[0] : 9'h000;
    req0_valid = (q0.size() > 0) && ($urandom_range(99) < v_pct);
    req1_valid = (q1.size() > 0) && ($urandom_range(99) < v_pct);
    req0_data  = req0_valid ? h0[7:0] : 8'($urandom);
    req1_data  = req1_valid ? h1[7:0] : 8'($urandom);
    req0_last  = req0_valid ? h0[8] : 1'($urandom);
    req1_last  = req1_valid ? h1[8] : 1'($urandom);
    in_wait = m_infl && (cyc >= entry);
    if (in_wait) done_s = (cyc == m_done_at);
    else if (m_flush) done_s = (cyc == stray_at);
    else done_s = ($urandom_range(99) < stray_pct);
    tx_done = done_s;
    clr_s = ($urandom_range(99) < clr_pct) || clr_once ||
            (clr_at_to && in_wait && cyc == entry + TO - 1);
    clr_once = 0;
    err_clr = clr_s;
    #1;
    // expected handshake
    acc = 0; who = 0;
    if (rst_n && !m_flush && !m_infl && cyc >= m_avail) begin
      if (m_locked) begin
        who = m_last;
        acc = m_last ? req1_valid : req0_valid;
      end else if (req0_valid && req1_valid) begin
        who = !m_last; acc = 1;
      end else if (req0_valid || req1_valid) begin
        who = req1_valid; acc = 1;
      end
    end
    if (m_armed) begin
      chk("req0_ready", req0_ready, acc && !who);
      chk("req1_ready", req1_ready, acc && who);
    end
    if (req0_ready === 1'b1 && req0_valid && q0.size() > 0) void'(q0.pop_front());
    if (req1_ready === 1'b1 && req1_valid && q1.size() > 0) void'(q1.pop_front());
    // advance model past this cycle
    if (!rst_n) begin
      m_armed = 1; m_flush = 1; m_flush_start = cyc + 1; m_infl = 0; m_locked = 0;
      m_last = 1; m_err = 0; m_chk_rst = 1; m_avail = 0;
      stray_at = (stray_flush_dly > 0) ? cyc + 1 + stray_flush_dly : -1;
    end else begin
      to = 0;
      if (m_flush) begin
        if (done_s || cyc == m_flush_start + TO - 1) begin m_flush = 0; m_avail = cyc + 1; end
      end else if (in_wait) begin
        if (done_s) begin
          m_infl = 0; m_avail = cyc + 1; m_locked = !m_lastflag;
        end else if (cyc == entry + TO - 1) begin
          to = 1; m_infl = 0; m_locked = 0; m_avail = cyc + 1;
        end
      end
      if (acc) begin
        h = who ? h1 : h0;
        m_infl = 1; m_start = cyc + 1; m_last = who;
        m_data = h[7:0]; m_lastflag = h[8]; m_par = who ? P1 : P0;
        dly = pick_dly();
        m_done_at = (dly == 0) ? -1 : m_start + dly;
      end
      if (to) m_err = 1;
      else if (clr_s) m_err = 0;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && model_idle()) && k < budget) begin
      step(); k++;
    end
    chk("drain", (q0.size() == 0 && q1.size() == 0 && model_idle()), 1'b1);
  endtask

  initial begin
    int k, len;
    bit side;
    // reset, then FLUSH expiring on its own
    rst_cnt = 3;
    drain(1000);
    // single byte, frame 297 cycles
    tx_mode = 0; tx_fixed = 297;
    q0.push_back({1'b1, 8'hA5});
    drain(1000);
    // contention, alternating single bytes
    tx_fixed = 20;
    for (int i = 0; i < 4; i++) begin q0.push_back({1'b1, 8'h11}); q1.push_back({1'b1, 8'h22}); end
    drain(2000);
    // packet lock on requester 1 while requester 0 waits
    q1.push_back({1'b0, 8'h01}); q1.push_back({1'b0, 8'h02}); q1.push_back({1'b1, 8'h03});
    step();
    q0.push_back({1'b1, 8'h44});
    drain(2000);
    // timeout with clear in the timeout cycle, then a real clear
    tx_fixed = 0; clr_at_to = 1;
    q0.push_back({1'b1, 8'h5A});
    drain(1000);
    clr_at_to = 0;
    clr_once = 1; step(); step();
    // timeout mid-packet releases the lock
    q1.push_back({1'b0, 8'h66}); q1.push_back({1'b1, 8'h67});
    drain(2000);
    clr_once = 1; step(); step();
    // completion on the last allowed cycle, then one cycle late
    tx_fixed = 400; q0.push_back({1'b1, 8'h3C}); drain(1000);
    tx_fixed = 401; q1.push_back({1'b1, 8'hC3}); drain(1000);
    clr_once = 1; step(); step();
    // reset mid-frame, stale tx_done 100 cycles into FLUSH
    tx_fixed = 0;
    q0.push_back({1'b1, 8'h77}); q0.push_back({1'b1, 8'h78});
    k = 0;
    while (!(m_infl && cyc >= m_start + 50) && k < 200) begin step(); k++; end
    chk("reach_wait", m_infl, 1'b1);
    rst_cnt = 1; stray_flush_dly = 100; tx_fixed = 30;
    drain(2000);
    stray_flush_dly = 0;
    // randomized traffic
    tx_mode = 1; v_pct = 70; stray_pct = 3; clr_pct = 2;
    for (int i = 0; i < 100; i++) begin
      side = 1'($urandom);
      len = $urandom_range(3, 1);
      for (int j = 0; j < len; j++) begin
        if (side) q1.push_back({(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        else      q0.push_back({(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
      end
      if (i == 50) begin rst_cnt = 1; stray_flush_dly = $urandom_range(300, 1); end
      if (i == 52) stray_flush_dly = 0;
      k = $urandom_range(20, 0);
      for (int j = 0; j < k; j++) step();
    end
    drain(40000);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
